// File: rtl/des_key_sched_arb.sv
// Round-robin scheduler sharing one pipelined DES core between two requesters.
// Holds the core key constant while blocks are in flight and tags each issue with its requester.
module des_key_sched_arb #(
  parameter int LAT       = 16,
  parameter int BURST_MAX = 8,
  parameter int DATA_W    = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [DATA_W-1:0] req0_key,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [DATA_W-1:0] req1_key,
  output logic [DATA_W-1:0] core_din,
  output logic              core_din_en,
  output logic [DATA_W-1:0] core_key,
  input  logic [DATA_W-1:0] core_dout,
  input  logic              core_dout_rdy,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_id,
  output logic              err
);
  localparam int IW = $clog2(LAT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);
  localparam logic [BW-1:0] BURST_TOP  = BW'(BURST_MAX);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_nxt;
  logic              owner, owner_nxt;
  logic              last_owner, last_owner_nxt;
  logic [DATA_W-1:0] key_nxt;
  logic [BW-1:0]     burst_cnt, burst_nxt;
  logic [IW-1:0]     inflight;
  logic [LAT-1:0]    tag_vld_p, tag_id_p;
  logic              own_valid, oth_valid, fire, grant, err_nxt;
  logic [DATA_W-1:0] oth_key;

  assign own_valid   = owner ? req1_valid : req0_valid;
  assign oth_valid   = owner ? req0_valid : req1_valid;
  assign oth_key     = owner ? req0_key   : req1_key;
  assign req0_ready  = (state == RUN) && !owner;
  assign req1_ready  = (state == RUN) && owner;
  assign fire        = (state == RUN) && own_valid;
  assign core_din    = owner ? req1_data : req0_data;
  assign core_din_en = fire;
  assign resp_valid  = core_dout_rdy;
  assign resp_data   = core_dout;
  assign resp_id     = tag_id_p[LAT-1];

  // A result with no block in flight, or out of step with the tag pipe, is a protocol fault.
  assign err_nxt = err || (core_dout_rdy && (inflight == '0))
                       || (core_dout_rdy != tag_vld_p[LAT-1]);

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    key_nxt        = core_key;
    burst_nxt      = burst_cnt;
    grant          = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant     = (req0_valid && req1_valid) ? !last_owner : req1_valid;
          owner_nxt = grant;
          key_nxt   = grant ? req1_key : req0_key;
          burst_nxt = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (fire) burst_nxt = burst_cnt + BW'(1);
        if (oth_valid && (!own_valid || (fire && burst_cnt == BURST_LAST))) begin
          last_owner_nxt = owner;
          // Same key: hand over without a bubble, the pipeline stays valid.
          if (oth_key == core_key) begin
            owner_nxt = !owner;
            burst_nxt = '0;
          end else begin
            state_nxt = DRAIN;
          end
        end else if (burst_nxt == BURST_TOP) begin
          burst_nxt = '0;
        end
      end
      DRAIN: begin
        if (inflight == '0) begin
          if (oth_valid) begin
            owner_nxt = !owner;
            key_nxt   = oth_key;
            burst_nxt = '0;
            state_nxt = RUN;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      core_key   <= '0;
      burst_cnt  <= '0;
      inflight   <= '0;
      tag_vld_p  <= '0;
      tag_id_p   <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      core_key   <= key_nxt;
      burst_cnt  <= burst_nxt;
      err        <= err_nxt;
      // Tag pipe stage boundary: mirrors the core latency so the tail lines up with core_dout_rdy.
      tag_vld_p  <= {tag_vld_p[LAT-2:0], fire};
      tag_id_p   <= {tag_id_p[LAT-2:0], owner};
      case ({fire, core_dout_rdy})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   if (inflight != '0) inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
    end
  end
endmodule
